// File: rtl/tick_stopwatch_pkg.sv
// Shared types and constants for the tick-driven mm:ss stopwatch.
// FSM states, BCD digit widths and per-digit rollover limits.
package tick_stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int UNIT_W = 4;
  localparam int TENS_W = 3;
  localparam int DISP_W = 2 * UNIT_W + 2 * TENS_W;

  localparam logic [UNIT_W-1:0] UNIT_MAX = 4'd9;
  localparam logic [TENS_W-1:0] TENS_MAX = 3'd5;

endpackage

// File: rtl/edge_sync.sv
// Synchronizer chain plus registered rising-edge detector.
// Rising edge of level appears on pulse SYNC_STAGES+1 clocks later; SYNC_STAGES >= 2.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], level};
      prev_q <= sync_q[SYNC_STAGES-1];
      pulse  <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/tick_stopwatch.sv
// Start/stop/clear mm:ss stopwatch advanced by a synchronized divider tick.
// Optional lap-freeze of the displayed digits under TICK_STOPWATCH_LAP_EN.
module tick_stopwatch
  import tick_stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int TICKS_PER_COUNT = 1
) (
  input  logic              inClk,
  input  logic              inRst_n,
  input  logic              inTick,
  input  logic              inStartStop,
  input  logic              inClear,
`ifdef TICK_STOPWATCH_LAP_EN
  input  logic              inLap,
`endif
  output logic [UNIT_W-1:0] outSecOnes,
  output logic [TENS_W-1:0] outSecTens,
  output logic [UNIT_W-1:0] outMinOnes,
  output logic [TENS_W-1:0] outMinTens,
  output logic              outRunning,
  output logic              outWrap
);

  localparam int PRE_W = (TICKS_PER_COUNT > 1) ? $clog2(TICKS_PER_COUNT) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_COUNT - 1);

  logic tick_p, ss_p, clr_p;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tick (
    .clk(inClk), .rst_n(inRst_n), .level(inTick), .pulse(tick_p));
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
    .clk(inClk), .rst_n(inRst_n), .level(inStartStop), .pulse(ss_p));
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clr (
    .clk(inClk), .rst_n(inRst_n), .level(inClear), .pulse(clr_p));

  state_t            state_q, state_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [UNIT_W-1:0] sec_ones_q, sec_ones_d, min_ones_q, min_ones_d;
  logic [TENS_W-1:0] sec_tens_q, sec_tens_d, min_tens_q, min_tens_d;
  logic              wrap_q, wrap_d;
  logic              running_q;
  logic              count_en;

  always_ff @(posedge inClk or negedge inRst_n) begin
    if (!inRst_n) begin
      state_q    <= ST_IDLE;
      pre_q      <= '0;
      sec_ones_q <= '0;
      sec_tens_q <= '0;
      min_ones_q <= '0;
      min_tens_q <= '0;
      wrap_q     <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      wrap_q     <= wrap_d;
      running_q  <= (state_d == ST_RUN);
    end
  end

  // The current state decides whether a tick counts, so a tick landing with
  // the RUN->PAUSE start/stop edge is still taken. Clear overrides everything.
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    wrap_d     = 1'b0;
    count_en   = 1'b0;

    case (state_q)
      ST_IDLE:  if (ss_p) state_d = ST_RUN;
      ST_RUN: begin
        if (ss_p) state_d = ST_PAUSE;
        count_en = tick_p;
      end
      ST_PAUSE: if (ss_p) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase

    if (count_en) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        if (sec_ones_q == UNIT_MAX) begin
          sec_ones_d = '0;
          if (sec_tens_q == TENS_MAX) begin
            sec_tens_d = '0;
            if (min_ones_q == UNIT_MAX) begin
              min_ones_d = '0;
              if (min_tens_q == TENS_MAX) begin
                min_tens_d = '0;
                wrap_d     = 1'b1;
              end else begin
                min_tens_d = min_tens_q + 3'd1;
              end
            end else begin
              min_ones_d = min_ones_q + 4'd1;
            end
          end else begin
            sec_tens_d = sec_tens_q + 3'd1;
          end
        end else begin
          sec_ones_d = sec_ones_q + 4'd1;
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end

    if (clr_p) begin
      state_d    = ST_IDLE;
      pre_d      = '0;
      sec_ones_d = '0;
      sec_tens_d = '0;
      min_ones_d = '0;
      min_tens_d = '0;
      wrap_d     = 1'b0;
    end
  end

  assign outRunning = running_q;
  assign outWrap    = wrap_q;

`ifdef TICK_STOPWATCH_LAP_EN
  logic              lap_p;
  logic              frozen_q, frozen_d;
  logic [DISP_W-1:0] snap_q, snap_d;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lap (
    .clk(inClk), .rst_n(inRst_n), .level(inLap), .pulse(lap_p));

  always_ff @(posedge inClk or negedge inRst_n) begin
    if (!inRst_n) begin
      frozen_q <= 1'b0;
      snap_q   <= '0;
    end else begin
      frozen_q <= frozen_d;
      snap_q   <= snap_d;
    end
  end

  // Each lap edge in RUN toggles the freeze; freezing captures the live digits.
  always_comb begin
    frozen_d = frozen_q;
    snap_d   = snap_q;
    if ((state_q == ST_RUN) && lap_p) begin
      frozen_d = ~frozen_q;
      snap_d   = {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};
    end
    if (clr_p) frozen_d = 1'b0;
  end

  assign {outMinTens, outMinOnes, outSecTens, outSecOnes} = frozen_q ? snap_q
         : {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};
`else
  assign outSecOnes = sec_ones_q;
  assign outSecTens = sec_tens_q;
  assign outMinOnes = min_ones_q;
  assign outMinTens = min_tens_q;
`endif

endmodule
